// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and defaults for the IF/MEM memory arbiter
package cpu_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_sel_e;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - grant decision between fetch and data; MEM_ARB_FAIR_EN adds a starvation counter
module mem_arb_pick
    import cpu_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic idle_i,
    input  logic if_req_i,
    input  logic dm_req_i,
    output logic gnt_valid_o,
    output logic gnt_sel_o
);

`ifdef MEM_ARB_FAIR_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             starved;

    // Once data has won STARVE_MAX times in a row over a waiting fetch, fetch gets one turn.
    assign starved = (starve_q == CNT_W'(STARVE_MAX)) && if_req_i;

    always_comb begin
        gnt_valid_o = idle_i && (if_req_i || dm_req_i);
        gnt_sel_o   = (dm_req_i && !starved) ? GNT_DM : GNT_IF;
        starve_d    = starve_q;
        if (idle_i) begin
            if (!if_req_i || (gnt_sel_o == GNT_IF)) begin
                starve_d = '0;
            end else if (starve_q != CNT_W'(STARVE_MAX)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = clk & reset & (STARVE_MAX > 0);

    // Data always wins: the older instruction is the one sitting in MEM.
    always_comb begin
        gnt_valid_o = idle_i && (if_req_i || dm_req_i);
        gnt_sel_o   = dm_req_i ? GNT_DM : GNT_IF;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for IF and MEM stages; optional MEM_ARB_FAIR_EN fairness
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_done,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                arb_busy
);

    arb_state_e          state_q, state_d;
    logic                gnt_valid;
    logic                gnt_sel;
    logic                mem_req_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W/8-1:0] mem_wstrb_q;
    logic                if_done_q, dm_done_q;
    logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;
    logic                ack_if, ack_dm;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk         (clk),
        .reset       (reset),
        .idle_i      (state_q == IDLE),
        .if_req_i    (if_req),
        .dm_req_i    (dm_req),
        .gnt_valid_o (gnt_valid),
        .gnt_sel_o   (gnt_sel)
    );

    // An ack only counts while an access is outstanding.
    assign ack_if = mem_ack && (state_q == BUSY_I);
    assign ack_dm = mem_ack && (state_q == BUSY_D);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:           if (gnt_valid) state_d = (gnt_sel == GNT_DM) ? BUSY_D : BUSY_I;
            BUSY_I, BUSY_D: if (mem_ack) state_d = DONE;
            DONE:           state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            if_done_q <= ack_if;
            dm_done_q <= ack_dm;
            if (gnt_valid) begin
                mem_req_q <= 1'b1;
                if (gnt_sel == GNT_DM) begin
                    mem_we_q    <= dm_we;
                    mem_addr_q  <= dm_addr;
                    mem_wdata_q <= dm_wdata;
                    mem_wstrb_q <= dm_wstrb;
                end else begin
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= if_addr;
                    mem_wdata_q <= '0;
                    mem_wstrb_q <= '0;
                end
            end else if (ack_if || ack_dm) begin
                mem_req_q <= 1'b0;
            end
            if (ack_if) if_rdata_q <= mem_rdata;
            if (ack_dm) dm_rdata_q <= mem_rdata;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_if  = if_req & ~if_done_q;
    assign stall_mem = dm_req & ~dm_done_q;
    assign arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level reference model
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [3:0]    dm_wstrb = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          stall_if, stall_mem;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          arb_busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .arb_busy(arb_busy)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: who owns the memory, who just finished, what was issued.
    int          m_owner = 0;   // 0 none, 1 fetch, 2 data
    int          m_done = 0;    // 0 none, 1 fetch, 2 data
    int          m_starve = 0;
    bit          m_starved;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_dm_rd = '0;
    logic [3:0]  m_strb = '0;

    always @(posedge clk) begin
        if (!reset) begin
            m_owner = 0; m_done = 0; m_starve = 0; m_if_rd = '0; m_dm_rd = '0;
        end else if (m_owner != 0) begin
            if (mem_ack) begin
                if (m_owner == 1) m_if_rd = mem_rdata;
                else m_dm_rd = mem_rdata;
                m_done = m_owner;
                m_owner = 0;
            end
        end else if (m_done != 0) begin
            m_done = 0;
        end else begin
            m_starved = FAIR && (m_starve >= SM) && if_req;
            if (dm_req && !m_starved) begin
                m_owner = 2; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_strb = dm_wstrb;
                m_starve = if_req ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
            end else if (if_req) begin
                m_owner = 1; m_we = 1'b0; m_addr = if_addr; m_wdata = '0; m_strb = '0;
                m_starve = 0;
            end else begin
                m_starve = 0;
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req", mem_req, m_owner != 0);
            chk("arb_busy", arb_busy, (m_owner != 0) || (m_done != 0));
            chk("if_done", if_done, m_done == 1);
            chk("dm_done", dm_done, m_done == 2);
            chk("stall_if", stall_if, if_req && (m_done != 1));
            chk("stall_mem", stall_mem, dm_req && (m_done != 2));
            if (m_owner != 0) begin
                chk("mem_we", mem_we, m_we);
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wstrb", mem_wstrb, m_strb);
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            if (m_done == 1) chk("if_rdata", if_rdata, m_if_rd);
            if (m_done == 2 && !m_we) chk("dm_rdata", dm_rdata, m_dm_rd);
        end
    end

    // Memory responder and requester behaviour, all driven 1 time unit after the edge.
    logic [31:0] mem_img [logic [31:0]];
    bit          ack_force_en = 1'b0;
    logic        ack_force_val = 1'b0;
    int          ack_lat = 1;
    int          ack_cnt = 0;
    int          cyc = 0;
    logic        prev_req = 1'b0;
    bit          auto_drop = 1'b1;
    bit          if_drop = 1'b0, dm_drop = 1'b0;
    logic [31:0] grant_addr [$];
    logic        grant_we [$];
    int          grant_cyc [$];

    function automatic logic [31:0] rd_value(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return {a[15:0], 16'hBEEF};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_req && !prev_req) begin
            grant_addr.push_back(mem_addr);
            grant_we.push_back(mem_we);
            grant_cyc.push_back(cyc);
        end
        prev_req = mem_req;
        if (auto_drop) begin
            if (if_drop) begin if_req = 1'b0; if_drop = 1'b0; end
            if (dm_drop) begin dm_req = 1'b0; dm_drop = 1'b0; end
            if (if_done) if_drop = 1'b1;
            if (dm_done) dm_drop = 1'b1;
        end
        mem_rdata = $urandom;
        if (ack_force_en) begin
            mem_ack = ack_force_val;
        end else if (mem_req) begin
            mem_ack = (ack_cnt == ack_lat);
            if (mem_ack) begin
                mem_rdata = rd_value(mem_addr);
                if (mem_we) mem_img[mem_addr] = mem_wdata;
            end
            ack_cnt++;
        end else begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; if_drop = 1'b0; dm_drop = 1'b0;
        step();
        step();
        reset = 1'b1;
        grant_addr.delete(); grant_we.delete(); grant_cyc.delete();
    endtask

    task automatic wait_done(input bit want_if, output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (want_if ? if_done : dm_done) begin
                n = i;
                break;
            end
        end
    endtask

    int  n, d_cyc;
    bit  saw;

    initial begin
        mem_img[32'h100] = 32'h0050_0093;
        mem_img[32'h104] = 32'h0000_0013;
        mem_img[32'h40]  = 32'h1234_5678;

        // Reset held with mem_ack high.
        ack_force_en = 1'b1; ack_force_val = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", arb_busy, 0);
        chk("rst_dones", {if_done, dm_done}, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        reset = 1'b1;
        step();
        step();
        chk("rst_ack_ignored", {arb_busy, mem_req, if_done, dm_done}, 0);
        ack_force_en = 1'b0;
        step();

        // Fetch only, memory answers two cycles after mem_req.
        ack_lat = 2;
        if_req = 1'b1; if_addr = 32'h100;
        #0 chk("fetch_stall_pending", stall_if, 1);
        wait_done(1'b1, n);
        chk("fetch_latency", n, 4);
        chk("fetch_rdata", if_rdata, 32'h0050_0093);
        chk("fetch_grants", grant_addr.size(), 1);
        if (grant_addr.size() >= 1) begin
            chk("fetch_addr", grant_addr[0], 32'h100);
            chk("fetch_we", grant_we[0], 0);
        end
        step();
        chk("fetch_done_pulse", if_done, 0);
        step();

        // Simultaneous store and fetch: store first, fetch after DONE plus one IDLE cycle.
        do_reset();
        ack_lat = 1;
        if_req = 1'b1; if_addr = 32'h104;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'hF;
        wait_done(1'b0, n);
        chk("store_done_seen", n > 0, 1);
        d_cyc = cyc;
        wait_done(1'b1, n);
        chk("fetch2_done_seen", n > 0, 1);
        chk("fetch2_rdata", if_rdata, 32'h0000_0013);
        for (int i = 0; i < 6; i++) step();
        chk("sim_grant_count", grant_addr.size(), 2);
        if (grant_addr.size() >= 2) begin
            chk("sim_first_addr", grant_addr[0], 32'h2000);
            chk("sim_first_we", grant_we[0], 1);
            chk("sim_second_addr", grant_addr[1], 32'h104);
            chk("sim_second_we", grant_we[1], 0);
            chk("sim_fetch_gap", grant_cyc[1] - d_cyc, 2);
        end
        chk("store_written", rd_value(32'h2000), 32'hDEAD_BEEF);

        // Reset while BUSY_D, then a late ack.
        do_reset();
        ack_lat = 50;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
        step();
        step();
        chk("busy_d_req", mem_req, 1);
        reset = 1'b0; dm_req = 1'b0;
        ack_force_en = 1'b1; ack_force_val = 1'b1;
        step();
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_busy", arb_busy, 0);
        reset = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            saw = saw | dm_done | arb_busy;
        end
        chk("late_ack_ignored", saw, 0);
        ack_force_en = 1'b0;
        step();

        // Zero-wait memory load.
        do_reset();
        ack_lat = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_wstrb = 4'h0;
        wait_done(1'b0, n);
        chk("zw_latency", n, 2);
        chk("zw_rdata", dm_rdata, 32'h1234_5678);
        step();
        step();

        // Continuous data traffic with a waiting fetch.
        do_reset();
        auto_drop = 1'b0;
        ack_lat = 1;
        if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4000;
        for (int i = 0; i < 100 && grant_addr.size() < 6; i++) step();
        chk("fair_grant_count", grant_addr.size() >= 6, 1);
        if (grant_addr.size() >= 6) begin
            for (int i = 0; i < 6; i++)
                chk($sformatf("fair_grant%0d", i), grant_addr[i],
                    (FAIR && i == 4) ? 32'h300 : 32'h4000);
        end
        dm_req = 1'b0; if_req = 1'b0; auto_drop = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("final_idle", arb_busy, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
